uart_rx_mmio: RTL and testbench

UART_RX_MMIO -- requirements
Module: uart_rx_mmio

---
 rtl/uart_rx_mmio.sv | 255 +++++++++++++++++++++++++
 tb/tb_uart_rx_mmio.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_mmio.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_mmio
// Purpose  : 8N1 UART receiver with an RX FIFO behind a small MMIO window.
//            The serial line is synchronised, oversampled by a baud counter
//            and framed by a four-state FSM. Completed bytes go into a FIFO
//            that the bus pops by reading RXDATA.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            rx                - asynchronous serial input (idle high)
//            bus_valid/write   - access strobe / direction (1 = write)
//            bus_addr          - byte address, word select in [3:2]
//                                (0 = RXDATA, 1 = STATUS)
//            bus_wdata         - write data (STATUS W1C bits 3/4)
//            uart_ready        - always 1, every access completes at once
//            mmio_rdata        - combinational read data for bus_addr
//            rx_irq            - level interrupt while the FIFO holds data
// Options  : UART_RX_ERR_FLAGS_EN - adds sticky W1C overrun/frame_err flags
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_mmio #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  input  logic        bus_valid,
  input  logic        bus_write,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic        uart_ready,
  output logic [31:0] mmio_rdata,
  output logic        rx_irq
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((CLKS_PER_BIT / 2) - 1);
  localparam logic [FIFO_AW:0] COUNT_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic               rx_meta_q, rx_s_q;
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic [FIFO_AW-1:0] wptr_q, wptr_d;
  logic [FIFO_AW-1:0] rptr_q, rptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [7:0]         mem [FIFO_DEPTH];

  logic push_req;     // stop bit sampled high: byte complete
  logic frame_evt;    // stop bit sampled low: byte discarded
  logic push_ok;
  logic overrun_evt;
  logic pop;
  logic empty, full;
  logic overrun, frame_err;

  // Two-flop synchroniser; resets to the idle line level so reset release
  // never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // --------------------------------------------------------------------------
  // Receive FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_evt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s_q) state_d = ST_START;
      end
      ST_START: begin
        // Half a bit in: confirm the start bit is still low (mid-bit).
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s_q ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          // Shift right so the first (LSB) bit ends up in bit 0.
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (rx_s_q) push_req  = 1'b1;
          else        frame_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // RX FIFO
  // --------------------------------------------------------------------------
  assign empty = (count_q == '0);
  assign full  = (count_q == COUNT_FULL);
  assign pop   = bus_valid && !bus_write && (bus_addr[3:2] == 2'd0) && !empty;
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign push_ok     = push_req && (!full || pop);
  assign overrun_evt = push_req && !push_ok;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop)     rptr_d = rptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; empty reads mask the head byte instead.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= shift_q;
  end

  // --------------------------------------------------------------------------
  // Error flags
  // --------------------------------------------------------------------------
`ifdef UART_RX_ERR_FLAGS_EN
  logic overrun_q, overrun_d;
  logic frame_err_q, frame_err_d;
  logic status_wr;

  assign status_wr = bus_valid && bus_write && (bus_addr[3:2] == 2'd1);

  // Set has priority over a simultaneous W1C.
  always_comb begin
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (status_wr && bus_wdata[3]) overrun_d   = 1'b0;
    if (status_wr && bus_wdata[4]) frame_err_d = 1'b0;
    if (overrun_evt)               overrun_d   = 1'b1;
    if (frame_evt)                 frame_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

  logic unused_ok;
  assign unused_ok = ^{bus_addr[31:4], bus_addr[1:0], bus_wdata};
`else
  assign overrun   = 1'b0;
  assign frame_err = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{bus_addr[31:4], bus_addr[1:0], bus_wdata,
                       overrun_evt, frame_evt};
`endif

  // --------------------------------------------------------------------------
  // Bus read side
  // --------------------------------------------------------------------------
  logic [7:0] count8;
  logic [7:0] head_byte;
  assign count8    = 8'(count_q);
  assign head_byte = empty ? 8'h00 : mem[rptr_q];

  always_comb begin
    mmio_rdata = 32'h0;
    case (bus_addr[3:2])
      2'd0:    mmio_rdata = {empty, 23'b0, head_byte};
      2'd1:    mmio_rdata = {16'b0, count8, 3'b0, frame_err, overrun,
                             full, empty, (state_q != ST_IDLE)};
      default: mmio_rdata = 32'h0;
    endcase
  end

  assign uart_ready = 1'b1;
  assign rx_irq     = !empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_mmio.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_mmio
// Purpose  : Self-checking bench for uart_rx_mmio (CLKS_PER_BIT = 8,
//            FIFO_DEPTH = 4). Every bus read queues its expected data and
//            interrupt level; a monitor compares them when the read is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_mmio;

  localparam int CPB = 8;
`ifdef UART_RX_ERR_FLAGS_EN
  localparam logic [31:0] OVR = 32'h8;
  localparam logic [31:0] FER = 32'h10;
`else
  localparam logic [31:0] OVR = 32'h0;
  localparam logic [31:0] FER = 32'h0;
`endif
  localparam logic [31:0] A_DATA = 32'h0;
  localparam logic [31:0] A_STAT = 32'h4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        bus_valid = 1'b0;
  logic        bus_write = 1'b0;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic        uart_ready;
  logic [31:0] mmio_rdata;
  logic        rx_irq;

  int total = 0;
  int bad   = 0;
  int tag_n = 0;

  logic [31:0] exp_data_q[$];
  logic        exp_irq_q[$];
  int          exp_tag_q[$];

  uart_rx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .bus_valid(bus_valid), .bus_write(bus_write),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .uart_ready(uart_ready), .mmio_rdata(mmio_rdata), .rx_irq(rx_irq)
  );

  always #5 clk = ~clk;

  // Monitor: a read is presented whenever bus_valid && !bus_write.
  always @(negedge clk) begin
    if (rst_n && bus_valid && !bus_write) begin
      if (exp_data_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_read addr=%h got=%h", bus_addr, mmio_rdata);
      end else begin
        logic [31:0] ed;
        logic        ei;
        int          et;
        ed = exp_data_q.pop_front();
        ei = exp_irq_q.pop_front();
        et = exp_tag_q.pop_front();
        total++;
        if (mmio_rdata !== ed) begin
          bad++;
          $display("FAIL rd%0d_rdata got=%h exp=%h", et, mmio_rdata, ed);
        end
        total++;
        if (rx_irq !== ei) begin
          bad++;
          $display("FAIL rd%0d_irq got=%b exp=%b", et, rx_irq, ei);
        end
        total++;
        if (uart_ready !== 1'b1) begin
          bad++;
          $display("FAIL rd%0d_ready got=%b exp=1", et, uart_ready);
        end
      end
    end
  end

  // All tasks start and end #1 after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp,
                          input logic exp_irq);
    tag_n++;
    exp_data_q.push_back(exp);
    exp_irq_q.push_back(exp_irq);
    exp_tag_q.push_back(tag_n);
    bus_valid = 1'b1;
    bus_write = 1'b0;
    bus_addr  = addr;
    idle(1);
    bus_valid = 1'b0;
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
    bus_valid = 1'b1;
    bus_write = 1'b1;
    bus_addr  = addr;
    bus_wdata = data;
    idle(1);
    bus_valid = 1'b0;
    bus_write = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop_bit;
    idle(CPB);
    rx = 1'b1;
  endtask

  initial begin
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Reset state and address decode.
    bus_read(A_STAT, 32'h0000_0002, 1'b0);
    bus_read(A_DATA, 32'h8000_0000, 1'b0);
    bus_read(32'h8, 32'h0, 1'b0);

    // Single byte, with ignored writes to RXDATA / unmapped words.
    send_byte(8'hA5, 1'b1);
    idle(2);
    bus_wr(A_DATA, 32'h0);
    bus_wr(32'hC, 32'hFFFF_FFFF);
    bus_read(A_STAT, 32'h0000_0100, 1'b1);
    bus_read(A_DATA, 32'h0000_00A5, 1'b1);
    bus_read(A_STAT, 32'h0000_0002, 1'b0);

    // 3-cycle glitch is rejected at the start-bit check.
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(20);
    bus_read(A_STAT, 32'h0000_0002, 1'b0);

    // Overflow: five bytes into four slots.
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    idle(2);
    bus_read(A_STAT, 32'h0000_0404 | OVR, 1'b1);
    bus_read(A_DATA, 32'h0000_0011, 1'b1);
    bus_read(A_DATA, 32'h0000_0022, 1'b1);
    bus_read(A_DATA, 32'h0000_0033, 1'b1);
    bus_read(A_DATA, 32'h0000_0044, 1'b1);
    bus_read(A_STAT, 32'h0000_0002 | OVR, 1'b0);
    bus_wr(A_STAT, 32'h8);
    bus_read(A_STAT, 32'h0000_0002, 1'b0);

    // Frame error: stop bit low.
    send_byte(8'h3C, 1'b0);
    idle(20);
    bus_read(A_STAT, 32'h0000_0002 | FER, 1'b0);
    bus_wr(A_STAT, 32'h10);
    bus_read(A_STAT, 32'h0000_0002, 1'b0);

    // Full FIFO, pop on the exact stop-sample edge of the fifth byte.
    // Stop sample lands 3 (sync + detect) + CPB/2 + 9*CPB edges after the
    // edge preceding the start bit = 79 edges.
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    idle(2);
    fork
      send_byte(8'h55, 1'b1);
      begin
        idle(3 + CPB / 2 + 9 * CPB - 1);
        bus_read(A_DATA, 32'h0000_0011, 1'b1);
      end
    join
    idle(2);
    bus_read(A_STAT, 32'h0000_0404, 1'b1);
    bus_read(A_DATA, 32'h0000_0022, 1'b1);
    bus_read(A_DATA, 32'h0000_0033, 1'b1);
    bus_read(A_DATA, 32'h0000_0044, 1'b1);
    bus_read(A_DATA, 32'h0000_0055, 1'b1);
    bus_read(A_STAT, 32'h0000_0002, 1'b0);

    // Reset during data bit 4 of 0xFF, then a clean frame.
    fork
      send_byte(8'hFF, 1'b1);
      begin
        idle(CPB + 4 * CPB + 4);
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
      end
    join
    idle(4);
    bus_read(A_STAT, 32'h0000_0002, 1'b0);
    send_byte(8'h5A, 1'b1);
    idle(2);
    bus_read(A_STAT, 32'h0000_0100, 1'b1);
    bus_read(A_DATA, 32'h0000_005A, 1'b1);
    bus_read(A_STAT, 32'h0000_0002, 1'b0);

    idle(2);
    total++;
    if (exp_data_q.size() != 0) begin
      bad++;
      $display("FAIL pending_reads got=%0d exp=0", exp_data_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog against a stuck run.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
